split_stream: RTL
=================

// Module: split_stream
// PURPOSE
//  Time-demultiplexing splitter: one serial word stream on in0 is distributed round-robin
//  into NUM_OUT registered output lanes (out0..out31), after a programmable start delay.
//  Counterpart of the merge unit; sits inside a Versat accelerator as a functional unit.
//  run/running/done follow the standard unit control contract.
// PARAMETERS
//  DELAY_W  32  width of delay0 and of the internal delay counter
//  DATA_W   32  data word width
//  NUM_OUT  32  active lanes, 2..32; lanes >= NUM_OUT are held at 0
//  LEN_W    16  width of length0 and of the word counter
// PORTS
//  clk      in   1        clock; all logic on posedge
//  rst      in   1        reset, synchronous, active-high
//  running  in   1        accelerator running; 0 freezes all state
//  run      in   1        start pulse: loads config, restarts the pass
//  in0      in   DATA_W   serial input word
//  out0..out31 out DATA_W lane registers; versat_latency = 1
//  done     out  1        registered; 1 when idle or pass complete
//  delay0   in   DELAY_W  config: running cycles ignored before the first capture
//  length0  in   LEN_W    config: words to capture; 0 = unbounded
// BEHAVIOUR
//  - Reset: out* = 0, lane = 0, delay = 0, words = 0, state = IDLE, done = 1.
//  - FSM IDLE -> WAIT on run. WAIT -> CAPT when delay == 0. CAPT -> DONE after length0 words.
//    run from any state returns to WAIT: restart mid-pass is legal.
//  - run has priority over running. It loads delay <= delay0, lane <= 0, words <= 0.
//    It samples length0 into len_q, sets done <= (length0 == 0), and leaves out* untouched.
//  - Cycle with running=0 and run=0: nothing changes.
//  - Cycle with running=1 and run=0:
//    - WAIT with delay != 0: delay <= delay - 1, no capture.
//    - WAIT with delay == 0, or CAPT: capture. out[lane] <= in0 and words <= words + 1.
//      lane <= (lane == NUM_OUT-1) ? 0 : lane + 1.
//  - Latency: in0 sampled at edge t is visible on out[lane] after edge t+1. Other lanes hold.
//  - delay0 = 0: capture starts on the first running cycle after run.
//  - Completion with len_q != 0: when the capture brings words to len_q, state <= DONE and
//    done <= 1 on that same edge. DONE ignores in0 until the next run.
//  - len_q == 0: unbounded. done stays 1 and the lane counter wraps forever.
//  - Words counter saturates at 2^LEN_W-1; no wrap.
//  - Reset mid-pass: immediate return to the reset values above.
// CONFIGURATION
//  SPLIT_LANE_VALID_EN defined: adds output lane_valid [31:0], reset 0.
//    run clears it; bit k is set on the same edge that writes out[k]. Unbounded mode keeps
//    bits set.
//  Not defined: port absent, no extra registers; behaviour otherwise identical.
// STRUCTURE
//  - Shared header split_defs.vh: state localparams, SPLIT_MAX_OUT = 32, lane index width
//    $clog2(SPLIT_MAX_OUT).
//  - Sub-module split_ctrl: FSM, delay/lane/words counters and done. Outputs cap_en and
//    lane_idx.
//  - Top level keeps the 32 lane registers, written as out[k] <= in0 when
//    cap_en && lane_idx == k.
// TESTING
//  1. delay0=0, length0=4, in0=10,11,12,13 on consecutive running cycles
//     -> out0..out3 = 10..13, each 1 cycle after its sample; done rises with 13; out4 = 0.
//  2. delay0=3, length0=1, in0 = 7,8,9,42 -> out0 = 42; done = 1 after that edge.
//  3. NUM_OUT=4, length0=6, in0=1..6 -> out0=5, out1=6, out2=3, out3=4; done = 1.
//  4. running=0 for 2 cycles between the 2nd and 3rd words -> no writes, lane holds;
//     3rd word still lands on out2.
//  5. run asserted after 3 captures, then in0=99 -> out0 = 99, out1/out2 keep old data.
//     rst mid-pass -> all out* = 0, done = 1.
//  6. SPLIT_LANE_VALID_EN, length0=3 -> lane_valid = 0x7 after 3 captures; next run -> 0.

Source files
------------

// File: rtl/split_stream_pkg.sv
// Shared types and constants for the split_stream splitter (state encoding, lane indexing).
// Optional feature macro used across this slice: SPLIT_LANE_VALID_EN.
package split_stream_pkg;

  localparam int SPLIT_MAX_OUT = 32;
  localparam int LANE_W        = $clog2(SPLIT_MAX_OUT);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_CAPT,
    ST_DONE
  } state_e;

  // Round-robin successor over the active lanes only.
  function automatic logic [LANE_W-1:0] next_lane(input logic [LANE_W-1:0] lane,
                                                  input int num_out);
    return (int'(lane) == num_out - 1) ? '0 : lane + 1'b1;
  endfunction

endpackage

// File: rtl/split_stream_if.sv
// Data-side bundle of split_stream: serial input word, lane registers and done.
// SPLIT_LANE_VALID_EN adds the per-lane written flags.
interface split_stream_if #(
  parameter int DATA_W = 32
);
  import split_stream_pkg::*;

  logic [DATA_W-1:0]                    in0;
  logic [SPLIT_MAX_OUT-1:0][DATA_W-1:0] out;
  logic                                 done;
`ifdef SPLIT_LANE_VALID_EN
  logic [SPLIT_MAX_OUT-1:0]             lane_valid;

  modport master (output in0, input out, done, lane_valid);
  modport slave  (input in0, output out, done, lane_valid);
`else
  modport master (output in0, input out, done);
  modport slave  (input in0, output out, done);
`endif

endinterface

// File: rtl/split_stream_ctrl.sv
// Pass control for split_stream: FSM plus delay/lane/word counters and the done flag.
// Produces cap_en (capture this cycle) and lane_idx (destination lane) for the top.
module split_stream_ctrl
  import split_stream_pkg::*;
#(
  parameter int DELAY_W = 32,
  parameter int LEN_W   = 16,
  parameter int NUM_OUT = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               running,
  input  logic               run,
  input  logic [DELAY_W-1:0] delay0,
  input  logic [LEN_W-1:0]   length0,
  output logic               cap_en,
  output logic [LANE_W-1:0]  lane_idx,
  output logic               done
);

  state_e             state_q, state_d;
  logic [DELAY_W-1:0] delay_q, delay_d;
  logic [LANE_W-1:0]  lane_q,  lane_d;
  logic [LEN_W-1:0]   words_q, words_d;
  logic [LEN_W-1:0]   len_q,   len_d;
  logic               done_q,  done_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      delay_q <= '0;
      lane_q  <= '0;
      words_q <= '0;
      len_q   <= '0;
      done_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      delay_q <= delay_d;
      lane_q  <= lane_d;
      words_q <= words_d;
      len_q   <= len_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    delay_d = delay_q;
    lane_d  = lane_q;
    words_d = words_q;
    len_d   = len_q;
    done_d  = done_q;
    cap_en  = 1'b0;

    if (run) begin
      state_d = ST_WAIT;
      delay_d = delay0;
      lane_d  = '0;
      words_d = '0;
      len_d   = length0;
      done_d  = (length0 == '0);
    end else if (running) begin
      case (state_q)
        ST_WAIT: begin
          if (delay_q != '0) delay_d = delay_q - 1'b1;
          else               cap_en  = 1'b1;
        end
        ST_CAPT: cap_en = 1'b1;
        default: ;
      endcase

      if (cap_en) begin
        state_d = ST_CAPT;
        lane_d  = next_lane(lane_q, NUM_OUT);
        if (words_q != '1) words_d = words_q + 1'b1;
        // len_q == 0 is the unbounded mode: never finishes, done stays high.
        if (len_q != '0 && words_d == len_q) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end
    end
  end

  assign lane_idx = lane_q;
  assign done     = done_q;

endmodule

// File: rtl/split_stream.sv
// split_stream: round-robin time-demultiplexer of in0 into NUM_OUT registered lanes.
// SPLIT_LANE_VALID_EN adds lane_valid: bit k set when lane k is written, cleared by run.
module split_stream
  import split_stream_pkg::*;
#(
  parameter int DELAY_W = 32,
  parameter int DATA_W  = 32,
  parameter int NUM_OUT = 32,
  parameter int LEN_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               running,
  input  logic               run,
  input  logic [DELAY_W-1:0] delay0,
  input  logic [LEN_W-1:0]   length0,
  split_stream_if.slave      bus
);

  logic                                 cap_en;
  logic [LANE_W-1:0]                    lane_idx;
  logic [SPLIT_MAX_OUT-1:0][DATA_W-1:0] out_q, out_d;

  split_stream_ctrl #(
    .DELAY_W (DELAY_W),
    .LEN_W   (LEN_W),
    .NUM_OUT (NUM_OUT)
  ) u_ctrl (
    .clk      (clk),
    .rst      (rst),
    .running  (running),
    .run      (run),
    .delay0   (delay0),
    .length0  (length0),
    .cap_en   (cap_en),
    .lane_idx (lane_idx),
    .done     (bus.done)
  );

  // Lanes at or above NUM_OUT are never selected, so they keep their reset value of 0.
  always_comb begin
    out_d = out_q;
    for (int k = 0; k < NUM_OUT; k++) begin
      if (cap_en && lane_idx == LANE_W'(k)) out_d[k] = bus.in0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) out_q <= '0;
    else     out_q <= out_d;
  end

  assign bus.out = out_q;

`ifdef SPLIT_LANE_VALID_EN
  logic [SPLIT_MAX_OUT-1:0] valid_q, valid_d;

  always_comb begin
    valid_d = valid_q;
    if (run) begin
      valid_d = '0;
    end else begin
      for (int k = 0; k < NUM_OUT; k++) begin
        if (cap_en && lane_idx == LANE_W'(k)) valid_d[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) valid_q <= '0;
    else     valid_q <= valid_d;
  end

  assign bus.lane_valid = valid_q;
`endif

endmodule
